// File: rtl/engine_pkg.sv
// Arbitration types and helpers shared by the state-vector access path.
package engine_pkg;

  typedef enum logic {
    OWNER_SEQ  = 1'b0,
    OWNER_HOST = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic       valid;
    arb_owner_e owner;
  } arb_tag_t;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v, input logic en);
    return (en && v != STAT_MAX) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fixed_point_pkg.sv
// Fixed-point amplitude types shared across the quantum engine datapath.
package fixed_point_pkg;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

endpackage

// File: rtl/state_vector_arbiter.sv
// Shares the state-vector BRAM between SEQ (priority) and HOST; one grant per cycle, HOST forced after MAX_WAIT.
// Latency: grant and BRAM controls same cycle, read data one cycle after grant; ungranted requesters hold.
// Optional grant/stall statistics counters are built only when ARB_STATS_EN is defined.
module state_vector_arbiter
  import fixed_point_pkg::*;
  import engine_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  seq_req,
  input  logic                  seq_we,
  input  logic [ADDR_WIDTH-1:0] seq_addr,
  input  complex_t              seq_wdata,
  input  logic                  seq_lock,
  output logic                  seq_gnt,
  output logic                  seq_rvalid,
  output complex_t              seq_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  complex_t              host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output complex_t              host_rdata,
  output logic                  bram_rd_en,
  output logic [ADDR_WIDTH-1:0] bram_rd_addr,
  output logic                  bram_wr_en,
  output logic [ADDR_WIDTH-1:0] bram_wr_addr,
  output complex_t              bram_wr_data,
  input  complex_t              bram_rd_data,
  output logic [31:0]           stat_seq_cnt,
  output logic [31:0]           stat_host_cnt,
  output logic [31:0]           stat_stall_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  arb_tag_t          tag_q, tag_d;
  logic              host_forced;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      tag_q      <= '{valid: 1'b0, owner: OWNER_SEQ};
    end else begin
      wait_cnt_q <= wait_cnt_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    seq_gnt      = 1'b0;
    host_gnt     = 1'b0;
    bram_rd_en   = 1'b0;
    bram_rd_addr = '0;
    bram_wr_en   = 1'b0;
    bram_wr_addr = '0;
    bram_wr_data = '0;
    host_forced  = host_req && (wait_cnt_q == WAIT_SAT);

    // Lock beats the starvation guard; a saturated counter fires on the first unlocked cycle.
    if (!rst) begin
      if (seq_lock)         seq_gnt  = seq_req;
      else if (host_forced) host_gnt = 1'b1;
      else if (seq_req)     seq_gnt  = 1'b1;
      else if (host_req)    host_gnt = 1'b1;
    end

    if (seq_gnt) begin
      bram_rd_en = !seq_we;
      bram_wr_en = seq_we;
      if (seq_we) begin
        bram_wr_addr = seq_addr;
        bram_wr_data = seq_wdata;
      end else begin
        bram_rd_addr = seq_addr;
      end
    end else if (host_gnt) begin
      bram_rd_en = !host_we;
      bram_wr_en = host_we;
      if (host_we) begin
        bram_wr_addr = host_addr;
        bram_wr_data = host_wdata;
      end else begin
        bram_rd_addr = host_addr;
      end
    end

    tag_d.valid = bram_rd_en;
    tag_d.owner = host_gnt ? OWNER_HOST : OWNER_SEQ;

    if (!host_req || host_gnt)      wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_SAT) wait_cnt_d = wait_cnt_q + 1'b1;
    else                             wait_cnt_d = wait_cnt_q;
  end

  always_comb begin
    seq_rvalid  = tag_q.valid && (tag_q.owner == OWNER_SEQ);
    host_rvalid = tag_q.valid && (tag_q.owner == OWNER_HOST);
    seq_rdata   = seq_rvalid  ? bram_rd_data : '0;
    host_rdata  = host_rvalid ? bram_rd_data : '0;
  end

`ifdef ARB_STATS_EN
  logic [31:0] stat_seq_cnt_q, stat_seq_cnt_d;
  logic [31:0] stat_host_cnt_q, stat_host_cnt_d;
  logic [31:0] stat_stall_cnt_q, stat_stall_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_seq_cnt_q   <= '0;
      stat_host_cnt_q  <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      stat_seq_cnt_q   <= stat_seq_cnt_d;
      stat_host_cnt_q  <= stat_host_cnt_d;
      stat_stall_cnt_q <= stat_stall_cnt_d;
    end
  end

  always_comb begin
    stat_seq_cnt_d   = sat_inc32(stat_seq_cnt_q, seq_gnt);
    stat_host_cnt_d  = sat_inc32(stat_host_cnt_q, host_gnt);
    stat_stall_cnt_d = sat_inc32(stat_stall_cnt_q, seq_req && !seq_gnt);
  end

  assign stat_seq_cnt   = stat_seq_cnt_q;
  assign stat_host_cnt  = stat_host_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`else
  assign stat_seq_cnt   = '0;
  assign stat_host_cnt  = '0;
  assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_state_vector_arbiter.sv
// Directed bench with a BRAM model; read responses are checked by a scoreboard monitor.
module tb_state_vector_arbiter;
  import fixed_point_pkg::*;

  localparam int AW = 10;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          seq_req, seq_we, seq_lock;
  logic [AW-1:0] seq_addr;
  complex_t      seq_wdata;
  logic          seq_gnt, seq_rvalid;
  complex_t      seq_rdata;
  logic          host_req, host_we;
  logic [AW-1:0] host_addr;
  complex_t      host_wdata;
  logic          host_gnt, host_rvalid;
  complex_t      host_rdata;
  logic          bram_rd_en, bram_wr_en;
  logic [AW-1:0] bram_rd_addr, bram_wr_addr;
  complex_t      bram_wr_data;
  complex_t      bram_rd_data;
  logic [31:0]   stat_seq_cnt, stat_host_cnt, stat_stall_cnt;

  logic [31:0] mem [0:(1<<AW)-1];
  exp_t        seq_q[$];
  exp_t        host_q[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  state_vector_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .seq_req(seq_req), .seq_we(seq_we), .seq_addr(seq_addr), .seq_wdata(seq_wdata),
    .seq_lock(seq_lock), .seq_gnt(seq_gnt), .seq_rvalid(seq_rvalid), .seq_rdata(seq_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .bram_rd_en(bram_rd_en), .bram_rd_addr(bram_rd_addr), .bram_wr_en(bram_wr_en),
    .bram_wr_addr(bram_wr_addr), .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data),
    .stat_seq_cnt(stat_seq_cnt), .stat_host_cnt(stat_host_cnt), .stat_stall_cnt(stat_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bram_wr_en) mem[bram_wr_addr] <= bram_wr_data;
    if (bram_rd_en) bram_rd_data <= mem[bram_rd_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(input string name, inout exp_t q[$], input logic [31:0] act);
    exp_t e;
    if (q.size() == 0) begin
      chk({name, "_unexpected_rvalid"}, 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk({name, "_cycle"}, cyc, e.cyc);
      chk({name, "_data"}, act, e.data);
    end
  endtask

  // Scoreboard monitor: every rvalid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (seq_rvalid) begin
      pop_chk("seq_rd", seq_q, seq_rdata);
      chk("host_rdata_idle", host_rdata, 32'd0);
    end
    if (host_rvalid) begin
      pop_chk("host_rd", host_q, host_rdata);
      chk("seq_rdata_idle", seq_rdata, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_seq(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    seq_req = req; seq_we = we; seq_addr = a; seq_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
    host_req = req; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic exp_seq(input logic [31:0] d);
    seq_q.push_back('{data: d, cyc: cyc + 1});
  endtask

  task automatic exp_host(input logic [31:0] d);
    host_q.push_back('{data: d, cyc: cyc + 1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    mem[5] = 32'h0001_0002;
    mem[7] = 32'h0003_0004;
    rst = 1'b1;
    seq_lock = 1'b0;
    set_seq(1'b0, 1'b0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0);
    bram_rd_data = '0;
    @(negedge clk);
    chk("rst_seq_rvalid", {31'd0, seq_rvalid}, 32'd0);
    chk("rst_host_rvalid", {31'd0, host_rvalid}, 32'd0);
    chk("rst_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    chk("rst_stat_seq", stat_seq_cnt, 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // 1: lone SEQ read of addr 5
    tick();
    set_seq(1'b1, 1'b0, 10'd5, '0);
    exp_seq(32'h0001_0002);
    @(negedge clk);
    chk("t1_seq_gnt", {31'd0, seq_gnt}, 32'd1);
    chk("t1_host_gnt", {31'd0, host_gnt}, 32'd0);
    chk("t1_rd_en", {31'd0, bram_rd_en}, 32'd1);
    chk("t1_rd_addr", 32'(bram_rd_addr), 32'd5);
    tick();
    set_seq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t1_idle_rd_en", {31'd0, bram_rd_en}, 32'd0);
    chk("t1_idle_rd_addr", 32'(bram_rd_addr), 32'd0);
    chk("t1_host_rvalid", {31'd0, host_rvalid}, 32'd0);

    // 2: SEQ held, HOST starved for 8 cycles then forced in
    for (int k = 0; k <= 8; k++) begin
      tick();
      set_seq(1'b1, 1'b0, 10'd5, '0);
      set_host(1'b1, 1'b0, 10'd7, '0);
      if (k < 8) exp_seq(32'h0001_0002);
      else       exp_host(32'h0003_0004);
      @(negedge clk);
      chk($sformatf("t2_seq_gnt_c%0d", k), {31'd0, seq_gnt}, (k < 8) ? 32'd1 : 32'd0);
      chk($sformatf("t2_host_gnt_c%0d", k), {31'd0, host_gnt}, (k < 8) ? 32'd0 : 32'd1);
    end
    tick();
    set_seq(1'b0, 1'b0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0);

    // 3: lock holds HOST out; unlock with saturated wait grants HOST immediately
    for (int k = 0; k < 20; k++) begin
      tick();
      seq_lock = 1'b1;
      set_seq(1'b1, 1'b1, 10'd100, 32'h0000_1000 + 32'(k));
      set_host(1'b1, 1'b0, 10'd7, '0);
      @(negedge clk);
      chk($sformatf("t3_lock_host_gnt_c%0d", k), {31'd0, host_gnt}, 32'd0);
      chk($sformatf("t3_lock_seq_gnt_c%0d", k), {31'd0, seq_gnt}, 32'd1);
    end
    tick();
    seq_lock = 1'b0;
    exp_host(32'h0003_0004);
    @(negedge clk);
    chk("t3_unlock_host_gnt", {31'd0, host_gnt}, 32'd1);
    chk("t3_unlock_seq_gnt", {31'd0, seq_gnt}, 32'd0);
    chk("t3_unlock_wr_en", {31'd0, bram_wr_en}, 32'd0);
    tick();
    set_seq(1'b0, 1'b0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0);

    // 4: same-cycle SEQ write and HOST read of addr 3
    tick();
    set_seq(1'b1, 1'b1, 10'd3, 32'h00AA_00BB);
    set_host(1'b1, 1'b0, 10'd3, '0);
    @(negedge clk);
    chk("t4_seq_gnt", {31'd0, seq_gnt}, 32'd1);
    chk("t4_host_gnt", {31'd0, host_gnt}, 32'd0);
    chk("t4_wr_en", {31'd0, bram_wr_en}, 32'd1);
    chk("t4_wr_addr", 32'(bram_wr_addr), 32'd3);
    chk("t4_wr_data", bram_wr_data, 32'h00AA_00BB);
    chk("t4_rd_en", {31'd0, bram_rd_en}, 32'd0);
    tick();
    set_seq(1'b0, 1'b0, '0, '0);
    exp_host(32'h00AA_00BB);
    @(negedge clk);
    chk("t4_host_gnt2", {31'd0, host_gnt}, 32'd1);
    chk("t4_rd_addr", 32'(bram_rd_addr), 32'd3);
    tick();
    set_host(1'b0, 1'b0, '0, '0);
    tick();
    @(negedge clk);
`ifdef ARB_STATS_EN
    chk("stat_seq", stat_seq_cnt, 32'd30);
    chk("stat_host", stat_host_cnt, 32'd3);
    chk("stat_stall", stat_stall_cnt, 32'd2);
`else
    chk("stat_seq_off", stat_seq_cnt, 32'd0);
    chk("stat_host_off", stat_host_cnt, 32'd0);
    chk("stat_stall_off", stat_stall_cnt, 32'd0);
`endif

    // 5: reset lands while a SEQ read is in flight and HOST is waiting
    tick();
    set_seq(1'b1, 1'b0, 10'd5, '0);
    set_host(1'b1, 1'b0, 10'd7, '0);
    @(negedge clk);
    chk("t5_seq_gnt", {31'd0, seq_gnt}, 32'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t5_seq_rvalid", {31'd0, seq_rvalid}, 32'd0);
    chk("t5_seq_rdata", seq_rdata, 32'd0);
    chk("t5_seq_gnt_rst", {31'd0, seq_gnt}, 32'd0);
    chk("t5_host_gnt_rst", {31'd0, host_gnt}, 32'd0);
    chk("t5_rd_en_rst", {31'd0, bram_rd_en}, 32'd0);
    chk("t5_rd_addr_rst", 32'(bram_rd_addr), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_wait_cnt", 32'(dut.wait_cnt_q), 32'd0);
    chk("t5_stat_seq", stat_seq_cnt, 32'd0);
    set_seq(1'b0, 1'b0, '0, '0);
    set_host(1'b0, 1'b0, '0, '0);

    // 6: saturating statistics
`ifdef ARB_STATS_EN
    tick();
    force dut.stat_seq_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_seq_cnt_q;
    for (int k = 0; k < 3; k++) begin
      tick();
      set_seq(1'b1, 1'b1, 10'd200, 32'(k));
    end
    tick();
    set_seq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t6_stat_sat", stat_seq_cnt, 32'hFFFF_FFFF);
`else
    for (int k = 0; k < 3; k++) begin
      tick();
      set_seq(1'b1, 1'b1, 10'd200, 32'(k));
    end
    tick();
    set_seq(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("t6_stat_seq_off", stat_seq_cnt, 32'd0);
    chk("t6_stat_stall_off", stat_stall_cnt, 32'd0);
`endif
    chk("t6_mem_written", mem[200], 32'd2);

    tick();
    tick();
    @(negedge clk);
    chk("sb_seq_drained", 32'(seq_q.size()), 32'd0);
    chk("sb_host_drained", 32'(host_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
